block_interleaver: RTL and testbench
====================================

Name: block_interleaver

Overview:
- Parametrised successor to the single-bit interleaver RAM in the FEC chain.
- Rectangular ROWS x COLS block interleaver/deinterleaver with DATA_W-bit symbols and a ping-pong (two-bank) memory.
- Sits between the encoder/decoder and the modulator/demodulator; the write and read sides are decoupled by valid/ready handshakes.
- Sustains 1 symbol/cycle in and out in steady state.

Parameters:
- DATA_W, 1: symbol width in bits; 1 gives the legacy bit interleaver.
- ROWS, 64: interleaver rows; must be at least 2.
- COLS, 256: interleaver columns; must be at least 2.
- N (localparam), ROWS*COLS: symbols per block.
- AW (localparam), $clog2(N): address width per bank.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = interleave, 1 = deinterleave; sampled on the first write of each block.
- s_valid  in  1  input symbol valid.
- s_ready  out  1  block can accept an input symbol.
- s_data  in  DATA_W  input symbol.
- m_valid  out  1  output symbol valid.
- m_ready  in  1  downstream accepts the output symbol.
- m_data  out  DATA_W  output symbol.
- m_last  out  1  high with the last symbol (index N-1) of each output block.
- busy  out  1  high when either bank is non-empty or a read is in flight.

Behaviour:
- Storage:
  - Two banks, each N x DATA_W, inferable as simple dual-port block RAM.
  - Registered (1-cycle) read. No initial file load; contents are undefined after reset.
- Bank state: each bank is EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY. Each bank has a mode bit latched at FILLING entry.
- Write side:
  - wr_bank selects the bank being filled. Write counters are wr_r (0..ROWS-1) and wr_c (0..COLS-1).
  - s_ready = 1 when bank[wr_bank] is EMPTY or FILLING.
  - A transfer (s_valid & s_ready) writes s_data at address wr_r*COLS + wr_c.
  - Interleave: wr_c increments fastest (row-major). Deinterleave: wr_r increments fastest (column-major).
  - After the N-th transfer: bank -> FULL, counters -> 0, wr_bank toggles.
  - If the new wr_bank is not EMPTY, s_ready drops next cycle and stays low until that bank returns to EMPTY.
- Read side:
  - rd_bank selects the bank being drained. Counters are rd_r and rd_c, both starting at 0.
  - A read issues when bank[rd_bank] is FULL or DRAINING and (skid occupancy + in-flight reads) < 2.
  - Interleave: rd_r increments fastest (column-major read). Deinterleave: rd_c increments fastest.
  - The first issue moves the bank FULL -> DRAINING.
  - After the N-th issue: bank -> EMPTY, counters -> 0, rd_bank toggles. The bank is immediately writable.
- Output stage:
  - 2-entry skid FIFO fed by the RAM read data.
  - m_valid = FIFO not empty; m_data/m_last come from the FIFO head. m_last is tagged at issue time for the N-th read.
  - m_data, m_valid and m_last are held stable while m_valid & !m_ready.
- Latency: 2 cycles from the FULL transition to the first m_valid (1 cycle issue, 1 cycle RAM).
- Throughput: with m_ready held high and s_valid held high, there are no bubbles in either stream after the first block.
- Simultaneous events:
  - A write completing bank A and a read completing bank B in the same cycle are both honoured.
  - Write-side and read-side state updates to the same bank never collide, because a bank is owned exclusively by one side per state.
- Address arithmetic: all counters are unsigned. The row*COLS + col computation is registered or incremental (add COLS / add 1 with wrap); no multiplier in the critical path.
- mode changes mid-block have no effect until the next block's first write.
- Reset (asynchronous, any time, including mid-block):
  - Banks -> EMPTY; wr_bank, rd_bank and all counters -> 0; skid FIFO emptied.
  - s_ready = 0 while rst_n is low, and 1 from the first clock after release.
  - m_valid = 0, m_last = 0, m_data = 0, busy = 0.
  - Partial blocks are discarded.

Test Plan:
- Interleave: ROWS=3, COLS=4, mode=0, input 0..11, m_ready=1 -> output 0,4,8,1,5,9,2,6,10,3,7,11; m_last only on the 11; first m_valid 2 cycles after the 12th input.
- Round trip: the interleaved stream from the previous test is fed back with mode=1 -> output 0..11 in order; 1000 random blocks with DATA_W=8 are also bit-exact.
- Back-pressure: m_ready held low, 3 full blocks offered -> s_ready drops after 24 accepted symbols (both banks full) and m_valid stays high with data 0 stable. Releasing m_ready gives the full 3-block output in order with no loss or duplication.
- Random m_ready/s_valid toggling (50%) over 200 blocks -> output matches the reference permutation model; m_last count = 200.
- Streaming: s_valid=1 and m_ready=1 continuous for 10 blocks -> s_ready never deasserts after reset release; m_valid is continuous from the first output to the last.
- Reset mid-block: rst_n pulsed low after 7 inputs of block 2 -> outputs go to 0 asynchronously; the next 12 inputs 100..111 produce exactly 100,104,108,101,... with no residue from before the reset.

Source files
------------

// File: rtl/block_interleaver.sv
// Rectangular ROWS x COLS block (de)interleaver with a ping-pong symbol memory.
// The write and read sides each own one bank at a time; a 2-entry skid FIFO decouples the output.
module block_interleaver #(
    parameter int unsigned DATA_W = 1,
    parameter int unsigned ROWS   = 64,
    parameter int unsigned COLS   = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
);

    localparam int unsigned N    = ROWS * COLS;
    localparam int unsigned AW   = $clog2(N);
    localparam int unsigned RowW = $clog2(ROWS);
    localparam int unsigned ColW = $clog2(COLS);

    localparam logic [RowW-1:0] RowMax   = RowW'(ROWS - 1);
    localparam logic [ColW-1:0] ColMax   = ColW'(COLS - 1);
    localparam logic [AW-1:0]   AddrStep = AW'(COLS);

    typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} bank_st_e;

    bank_st_e st_q [2];
    bank_st_e st_d [2];
    logic     bank_mode_q [2];
    logic     bank_mode_d [2];

    logic            rdy_en_q;
    logic            wr_bank_q, wr_bank_d;
    logic [RowW-1:0] wr_r_q, wr_r_d;
    logic [ColW-1:0] wr_c_q, wr_c_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic            wr_fire, wr_last, wr_mode;

    logic            rd_bank_q, rd_bank_d;
    logic [RowW-1:0] rd_r_q, rd_r_d;
    logic [ColW-1:0] rd_c_q, rd_c_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            rd_issue, rd_last, rd_mode;
    logic [2:0]      occ;

    logic              inflight_q, inflight_last_q, rd_sel_q;
    logic [DATA_W-1:0] rd0_q, rd1_q, rd_data;

    logic [DATA_W-1:0] fifo_data_q [2];
    logic              fifo_last_q [2];
    logic              fifo_wp_q, fifo_rp_q;
    logic [1:0]        fifo_cnt_q;
    logic              push, pop;

    logic [DATA_W-1:0] mem0 [N];
    logic [DATA_W-1:0] mem1 [N];

    // Handshake decode
    always_comb begin
        s_ready = rdy_en_q &&
                  (st_q[wr_bank_q] == StEmpty || st_q[wr_bank_q] == StFilling);
        wr_fire = s_valid && s_ready;
        // The mode of a block is taken from the input on its first write only.
        wr_mode = (st_q[wr_bank_q] == StEmpty) ? mode : bank_mode_q[wr_bank_q];
        wr_last = (wr_r_q == RowMax) && (wr_c_q == ColMax);

        pop     = m_valid && m_ready;
        push    = inflight_q;
        occ     = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
        rd_mode = bank_mode_q[rd_bank_q];
        rd_last = (rd_r_q == RowMax) && (rd_c_q == ColMax);
        rd_issue = (st_q[rd_bank_q] == StFull || st_q[rd_bank_q] == StDraining) &&
                   (occ < 3'd2);
    end

    // Write counters: incremental address, +1 along a row or +COLS down a column
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_r_d    = wr_r_q;
        wr_c_d    = wr_c_q;
        wr_addr_d = wr_addr_q;
        if (wr_fire) begin
            if (wr_last) begin
                wr_bank_d = ~wr_bank_q;
                wr_r_d    = '0;
                wr_c_d    = '0;
                wr_addr_d = '0;
            end else if (!wr_mode) begin
                wr_addr_d = wr_addr_q + AW'(1);
                if (wr_c_q == ColMax) begin
                    wr_c_d = '0;
                    wr_r_d = wr_r_q + RowW'(1);
                end else begin
                    wr_c_d = wr_c_q + ColW'(1);
                end
            end else begin
                if (wr_r_q == RowMax) begin
                    wr_r_d    = '0;
                    wr_c_d    = wr_c_q + ColW'(1);
                    wr_addr_d = AW'(wr_c_q) + AW'(1);
                end else begin
                    wr_r_d    = wr_r_q + RowW'(1);
                    wr_addr_d = wr_addr_q + AddrStep;
                end
            end
        end
    end

    // Read counters: interleave reads column-major, deinterleave row-major
    always_comb begin
        rd_bank_d = rd_bank_q;
        rd_r_d    = rd_r_q;
        rd_c_d    = rd_c_q;
        rd_addr_d = rd_addr_q;
        if (rd_issue) begin
            if (rd_last) begin
                rd_bank_d = ~rd_bank_q;
                rd_r_d    = '0;
                rd_c_d    = '0;
                rd_addr_d = '0;
            end else if (!rd_mode) begin
                if (rd_r_q == RowMax) begin
                    rd_r_d    = '0;
                    rd_c_d    = rd_c_q + ColW'(1);
                    rd_addr_d = AW'(rd_c_q) + AW'(1);
                end else begin
                    rd_r_d    = rd_r_q + RowW'(1);
                    rd_addr_d = rd_addr_q + AddrStep;
                end
            end else begin
                rd_addr_d = rd_addr_q + AW'(1);
                if (rd_c_q == ColMax) begin
                    rd_c_d = '0;
                    rd_r_d = rd_r_q + RowW'(1);
                end else begin
                    rd_c_d = rd_c_q + ColW'(1);
                end
            end
        end
    end

    // Bank ownership: the writer only touches EMPTY/FILLING banks, the reader FULL/DRAINING
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            st_d[b]        = st_q[b];
            bank_mode_d[b] = bank_mode_q[b];
        end
        if (wr_fire) begin
            if (st_q[wr_bank_q] == StEmpty) begin
                st_d[wr_bank_q]        = StFilling;
                bank_mode_d[wr_bank_q] = mode;
            end
            if (wr_last) begin
                st_d[wr_bank_q] = StFull;
            end
        end
        if (rd_issue) begin
            if (st_q[rd_bank_q] == StFull) begin
                st_d[rd_bank_q] = StDraining;
            end
            if (rd_last) begin
                st_d[rd_bank_q] = StEmpty;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]        <= StEmpty;
                bank_mode_q[b] <= 1'b0;
            end
            rdy_en_q        <= 1'b0;
            wr_bank_q       <= 1'b0;
            wr_r_q          <= '0;
            wr_c_q          <= '0;
            wr_addr_q       <= '0;
            rd_bank_q       <= 1'b0;
            rd_r_q          <= '0;
            rd_c_q          <= '0;
            rd_addr_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_sel_q        <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                st_q[b]        <= st_d[b];
                bank_mode_q[b] <= bank_mode_d[b];
            end
            rdy_en_q        <= 1'b1;
            wr_bank_q       <= wr_bank_d;
            wr_r_q          <= wr_r_d;
            wr_c_q          <= wr_c_d;
            wr_addr_q       <= wr_addr_d;
            rd_bank_q       <= rd_bank_d;
            rd_r_q          <= rd_r_d;
            rd_c_q          <= rd_c_d;
            rd_addr_q       <= rd_addr_d;
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && rd_last;
            rd_sel_q        <= rd_bank_q;
        end
    end

    // Symbol memories: one write port, one registered read port each
    always_ff @(posedge clk) begin
        if (wr_fire && !wr_bank_q) begin
            mem0[wr_addr_q] <= s_data;
        end
        if (rd_issue && !rd_bank_q) begin
            rd0_q <= mem0[rd_addr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire && wr_bank_q) begin
            mem1[wr_addr_q] <= s_data;
        end
        if (rd_issue && rd_bank_q) begin
            rd1_q <= mem1[rd_addr_q];
        end
    end

    assign rd_data = rd_sel_q ? rd1_q : rd0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < 2; e++) begin
                fifo_data_q[e] <= '0;
                fifo_last_q[e] <= 1'b0;
            end
            fifo_wp_q  <= 1'b0;
            fifo_rp_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[fifo_wp_q] <= rd_data;
                fifo_last_q[fifo_wp_q] <= inflight_last_q;
                fifo_wp_q              <= ~fifo_wp_q;
            end
            if (pop) begin
                fifo_rp_q <= ~fifo_rp_q;
            end
            fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
        end
    end

    always_comb begin
        m_valid = (fifo_cnt_q != 2'd0);
        m_data  = fifo_data_q[fifo_rp_q];
        m_last  = m_valid && fifo_last_q[fifo_rp_q];
        busy    = (st_q[0] != StEmpty) || (st_q[1] != StEmpty) || inflight_q ||
                  (fifo_cnt_q != 2'd0);
    end

endmodule

// File: tb/tb_block_interleaver.sv
// Self-checking bench for block_interleaver (3x4, 8-bit symbols) against a
// permutation model computed from row/column index arithmetic.
module tb_block_interleaver;

    localparam int ROWS = 3;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst_n, mode, s_valid, s_ready, m_valid, m_ready, m_last, busy;
    logic [DW-1:0] s_data, m_data;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    logic [7:0] in_blk[$];
    logic       blk_mode;
    logic [7:0] src_q[$];
    logic [7:0] obs_q[$];
    logic       obs_last[$];
    logic [7:0] orig[$];

    bit         s_fire_g, stream_chk, seen_out, hold_prev, toggle_mode;
    logic [9:0] hold_val;
    int         sready_drop, mvalid_gap, hold_err, last_cnt, last0, mism;
    logic [7:0] ilv [12] = '{8'd0, 8'd4, 8'd8, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd10, 8'd3, 8'd7, 8'd11};

    block_interleaver #(.DATA_W(DW), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output j of a block is input element (r,c); row-major index for interleave,
    // column-major write order for deinterleave.
    function automatic void model_push();
        for (int j = 0; j < N; j++) begin
            int k;
            if (!blk_mode) k = (j % ROWS) * COLS + (j / ROWS);
            else           k = (j % COLS) * ROWS + (j / COLS);
            exp_q.push_back({(j == N - 1), in_blk[k]});
        end
        in_blk.delete();
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        logic       sf, mf;
        logic [8:0] e;
        #1;
        sf = s_valid && s_ready;
        mf = m_valid && m_ready;
        if (stream_chk && s_valid && !s_ready) sready_drop++;
        if (stream_chk && seen_out && !m_valid && exp_q.size() > 0) mvalid_gap++;
        if (m_valid) seen_out = 1'b1;
        if (hold_prev && ({m_valid, m_last, m_data} !== hold_val)) hold_err++;
        hold_prev = m_valid && !m_ready;
        hold_val  = {m_valid, m_last, m_data};
        if (mf) begin
            check("out_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("m_data", m_data, e[7:0]);
                check("m_last", m_last, e[8]);
            end
            obs_q.push_back(m_data);
            obs_last.push_back(m_last);
            if (m_last) last_cnt++;
        end
        s_fire_g = sf;
        if (sf) begin
            if (in_blk.size() == 0) blk_mode = mode;
            in_blk.push_back(s_data);
            if (in_blk.size() == N) model_push();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input int vpct, input int rpct, input int max_cyc, input bit wait_drain);
        int n = 0;
        while ((src_q.size() > 0 || (wait_drain && exp_q.size() > 0)) && n < max_cyc) begin
            s_valid = (src_q.size() > 0) && (int'($urandom_range(99)) < vpct);
            s_data  = (src_q.size() > 0) ? src_q[0] : '0;
            m_ready = (int'($urandom_range(99)) < rpct);
            if (toggle_mode) mode = 1'($urandom_range(1));
            cycle();
            if (s_fire_g) void'(src_q.pop_front());
            n++;
        end
        s_valid = 1'b0;
        if (wait_drain) check("drain_done", src_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b1; mode = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel_s_ready", s_ready, 1);

        // Directed interleave with first-output latency
        for (int i = 0; i < N; i++) src_q.push_back(8'(i));
        mode = 1'b0;
        drive(100, 100, 50, 1'b0);
        check("lat_c0", m_valid, 0);
        check("busy_full", busy, 1);
        cycle();
        check("lat_c1", m_valid, 0);
        cycle();
        check("lat_c2", m_valid, 1);
        drive(100, 100, 100, 1'b1);
        check("ilv_count", obs_q.size(), N);
        for (int j = 0; j < N && j < obs_q.size(); j++) begin
            check("ilv_data", obs_q[j], ilv[j]);
            check("ilv_last", obs_last[j], (j == N - 1));
        end

        // Feed the interleaved stream back through deinterleave
        src_q = obs_q;
        obs_q.delete(); obs_last.delete();
        mode = 1'b1;
        drive(100, 100, 100, 1'b1);
        for (int j = 0; j < N && j < obs_q.size(); j++) check("rt_data", obs_q[j], j);
        check("rt_count", obs_q.size(), N);

        // Back-pressure: both banks fill, then output stalls on the first symbol
        obs_q.delete(); obs_last.delete();
        for (int i = 0; i < 3 * N; i++) src_q.push_back(8'(i));
        mode = 1'b0;
        drive(100, 0, 60, 1'b0);
        check("bp_accepted", 3 * N - src_q.size(), 2 * N);
        check("bp_s_ready", s_ready, 0);
        check("bp_m_valid", m_valid, 1);
        check("bp_m_data", m_data, 0);
        check("bp_busy", busy, 1);
        last0 = last_cnt;
        drive(100, 100, 300, 1'b1);
        check("bp_count", obs_q.size(), 3 * N);
        for (int j = 0; j < obs_q.size() && j < 3 * N; j++)
            check("bp_order", obs_q[j], (j / N) * N + ilv[j % N]);
        check("bp_lasts", last_cnt - last0, 3);

        // 200 random blocks, 50% valid/ready, mode toggling mid-block
        for (int i = 0; i < 200 * N; i++) src_q.push_back(8'($urandom));
        toggle_mode = 1'b1;
        last0 = last_cnt;
        drive(50, 50, 40000, 1'b1);
        toggle_mode = 1'b0;
        check("rand_lasts", last_cnt - last0, 200);

        // Continuous streaming of 10 blocks
        stream_chk = 1'b1; seen_out = 1'b0; sready_drop = 0; mvalid_gap = 0;
        for (int i = 0; i < 10 * N; i++) src_q.push_back(8'($urandom));
        mode = 1'b1;
        drive(100, 100, 400, 1'b1);
        stream_chk = 1'b0;
        check("stream_s_ready_drops", sready_drop, 0);
        check("stream_m_valid_gaps", mvalid_gap, 0);

        // 1000 random round trips
        mism = 0;
        for (int b = 0; b < 1000; b++) begin
            orig.delete();
            for (int i = 0; i < N; i++) orig.push_back(8'($urandom));
            src_q = orig;
            obs_q.delete(); obs_last.delete();
            mode = 1'b0;
            drive(100, 100, 100, 1'b1);
            src_q = obs_q;
            obs_q.delete(); obs_last.delete();
            mode = 1'b1;
            drive(100, 100, 100, 1'b1);
            if (obs_q.size() != N) mism++;
            for (int j = 0; j < N && j < obs_q.size(); j++)
                if (obs_q[j] !== orig[j]) mism++;
        end
        check("roundtrip_1000", mism, 0);

        // Reset in the middle of block 2 with output pending
        for (int i = 0; i < N + 7; i++) src_q.push_back(8'(50 + i));
        mode = 1'b0;
        drive(100, 0, 60, 1'b0);
        check("pre_rst_m_valid", m_valid, 1);
        check("pre_rst_m_data", m_data, 50);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_m_last", m_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_s_ready", s_ready, 0);
        exp_q.delete(); in_blk.delete(); src_q.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete(); obs_last.delete();
        for (int i = 0; i < N; i++) src_q.push_back(8'(100 + i));
        drive(100, 100, 100, 1'b1);
        check("post_rst_count", obs_q.size(), N);
        for (int j = 0; j < N && j < obs_q.size(); j++)
            check("post_rst_data", obs_q[j], 100 + ilv[j]);

        check("hold_stable", hold_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
